harmonic_phase_engine: RTL and testbench

Parametrised phase-accumulator engine for the additive oscillator. On each sample tick it walks harmonics 0..N-1 and derives each harmonic's frequency from the fundamental plus an alternating cumulative scale offset. It advances that harmonic's stored phase and presents a sine-LUT address to the mixer over a valid/ready handshake. It adds a runtime harmonic count, hard sync, early frame termination above a frequency limit, and a self-clearing phase memory.

---
 rtl/harmonic_phase_engine.sv | 200 ++++++++++++++++++++
 tb/tb_harmonic_phase_engine.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/harmonic_phase_engine.sv
// Phase-accumulator engine for the additive oscillator: walks harmonics per sample tick,
// derives each harmonic's increment from an alternating cumulative offset and streams LUT addresses.
module harmonic_phase_engine #(
    parameter int PHASE_W    = 16,
    parameter int FREQ_W     = 16,
    parameter int LUT_ADDR_W = 11,
    parameter int HARMONICS  = 64,
    parameter int HARM_W     = 7,
    parameter int FREQ_LIMIT = 20000
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Start,
    input  logic                  i_Sync,
    input  logic [FREQ_W-1:0]     i_Frequency,
    input  logic [FREQ_W-1:0]     i_Freq_Scale,
    input  logic [HARM_W-1:0]     i_Harmonic_Count,
    input  logic                  i_Ready,
    output logic                  o_Valid,
    output logic [LUT_ADDR_W-1:0] o_LUT_Addr,
    output logic [HARM_W-1:0]     o_Harmonic,
    output logic                  o_Busy,
    output logic                  o_Frame_Done,
    output logic                  o_Freq_Too_High
);

    localparam int ACC_W  = FREQ_W + HARM_W + 2;
    localparam int MEM_AW = $clog2(HARMONICS);

    localparam logic [2:0] S_CLEAR   = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_READ    = 3'd2;
    localparam logic [2:0] S_UPDATE  = 3'd3;
    localparam logic [2:0] S_PRESENT = 3'd4;
    localparam logic [2:0] S_OFFSET  = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic signed [ACC_W-1:0] LIMIT_C      = ACC_W'(FREQ_LIMIT);
    localparam logic [HARM_W-1:0]       HARM_MAX_C   = HARM_W'(HARMONICS);
    localparam logic [HARM_W-1:0]       CLEAR_LAST_C = HARM_W'(HARMONICS - 1);
    localparam logic [HARM_W-1:0]       ONE_H_C      = HARM_W'(1);

    logic [2:0]              state_r;
    logic [2:0]              state_next_s;
    logic [HARM_W-1:0]       h_r;
    logic [HARM_W-1:0]       h_inc_s;
    logic [HARM_W-1:0]       count_r;
    logic [HARM_W-1:0]       count_clamp_s;
    logic                    sync_r;
    logic [FREQ_W-1:0]       freq_base_r;
    logic [FREQ_W-1:0]       scale_step_r;
    logic signed [ACC_W-1:0] freq_acc_r;
    logic signed [ACC_W-1:0] scale_acc_r;
    logic signed [ACC_W-1:0] freq_base_ext_s;
    logic signed [ACC_W-1:0] scale_step_ext_s;
    logic signed [ACC_W-1:0] offset_sum_s;
    logic signed [ACC_W-1:0] freq_next_s;
    logic [PHASE_W-1:0]      phase_mem_r [HARMONICS];
    logic [PHASE_W-1:0]      phase_rd_r;
    logic [PHASE_W-1:0]      phase_new_s;
    logic                    valid_r;
    logic [LUT_ADDR_W-1:0]   lut_addr_r;
    logic [HARM_W-1:0]       harm_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    too_high_r;

    assign o_Valid         = valid_r;
    assign o_LUT_Addr      = lut_addr_r;
    assign o_Harmonic      = harm_r;
    assign o_Busy          = busy_r;
    assign o_Frame_Done    = done_r;
    assign o_Freq_Too_High = too_high_r;

    // Datapath helpers: phase update, alternating offset step with clamp at zero, count clamp
    always_comb begin
        h_inc_s          = h_r + ONE_H_C;
        freq_base_ext_s  = $signed({{(ACC_W - FREQ_W){1'b0}}, freq_base_r});
        scale_step_ext_s = $signed({{(ACC_W - FREQ_W){1'b0}}, scale_step_r});
        if (sync_r) begin
            phase_new_s = freq_acc_r[PHASE_W-1:0];
        end else begin
            phase_new_s = phase_rd_r + freq_acc_r[PHASE_W-1:0];
        end
        if (h_r[0]) begin
            offset_sum_s = freq_acc_r + freq_base_ext_s + scale_acc_r;
        end else begin
            offset_sum_s = freq_acc_r + freq_base_ext_s - scale_acc_r;
        end
        if (offset_sum_s[ACC_W-1]) begin
            freq_next_s = {ACC_W{1'b0}};
        end else begin
            freq_next_s = offset_sum_s;
        end
        if (i_Harmonic_Count == {HARM_W{1'b0}}) begin
            count_clamp_s = ONE_H_C;
        end else if (i_Harmonic_Count > HARM_MAX_C) begin
            count_clamp_s = HARM_MAX_C;
        end else begin
            count_clamp_s = i_Harmonic_Count;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_CLEAR:   state_next_s = (h_r == CLEAR_LAST_C) ? S_IDLE : S_CLEAR;
            S_IDLE:    state_next_s = i_Start ? S_READ : S_IDLE;
            S_READ:    state_next_s = (freq_acc_r > LIMIT_C) ? S_DONE : S_UPDATE;
            S_UPDATE:  state_next_s = S_PRESENT;
            S_PRESENT: state_next_s = i_Ready ? S_OFFSET : S_PRESENT;
            S_OFFSET:  state_next_s = (h_inc_s == count_r) ? S_DONE : S_READ;
            S_DONE:    state_next_s = S_IDLE;
            default:   state_next_s = S_CLEAR;
        endcase
    end

    // Control registers, frame latches and registered outputs
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_r      <= S_CLEAR;
            h_r          <= {HARM_W{1'b0}};
            count_r      <= ONE_H_C;
            sync_r       <= 1'b0;
            freq_base_r  <= {FREQ_W{1'b0}};
            scale_step_r <= {FREQ_W{1'b0}};
            freq_acc_r   <= {ACC_W{1'b0}};
            scale_acc_r  <= {ACC_W{1'b0}};
            valid_r      <= 1'b0;
            lut_addr_r   <= {LUT_ADDR_W{1'b0}};
            harm_r       <= {HARM_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            too_high_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != S_IDLE);
            done_r  <= (state_next_s == S_DONE);
            case (state_r)
                S_CLEAR: begin
                    h_r <= (h_r == CLEAR_LAST_C) ? {HARM_W{1'b0}} : h_inc_s;
                end
                S_IDLE: begin
                    if (i_Start) begin
                        freq_base_r  <= i_Frequency;
                        scale_step_r <= i_Freq_Scale;
                        freq_acc_r   <= $signed({{(ACC_W - FREQ_W){1'b0}}, i_Frequency});
                        scale_acc_r  <= $signed({{(ACC_W - FREQ_W){1'b0}}, i_Freq_Scale});
                        count_r      <= count_clamp_s;
                        sync_r       <= i_Sync;
                        h_r          <= {HARM_W{1'b0}};
                        too_high_r   <= 1'b0;
                    end
                end
                S_READ: begin
                    if (freq_acc_r > LIMIT_C) begin
                        too_high_r <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    valid_r    <= 1'b1;
                    lut_addr_r <= phase_new_s[PHASE_W-1 -: LUT_ADDR_W];
                    harm_r     <= h_r;
                end
                S_PRESENT: begin
                    if (i_Ready) begin
                        valid_r <= 1'b0;
                    end
                end
                S_OFFSET: begin
                    freq_acc_r <= freq_next_s;
                    if (h_r[0]) begin
                        scale_acc_r <= scale_acc_r + scale_step_ext_s;
                    end
                    h_r <= h_inc_s;
                end
                S_DONE: begin
                    valid_r <= 1'b0;
                end
                default: begin
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Phase memory: zero-fill while clearing, write-back on update, registered read
    always_ff @(posedge i_Clock) begin
        if (state_r == S_CLEAR) begin
            phase_mem_r[h_r[MEM_AW-1:0]] <= {PHASE_W{1'b0}};
        end else if (state_r == S_UPDATE) begin
            phase_mem_r[h_r[MEM_AW-1:0]] <= phase_new_s;
        end
        if (state_r == S_READ) begin
            phase_rd_r <= phase_mem_r[h_r[MEM_AW-1:0]];
        end
    end

endmodule

// File: tb/tb_harmonic_phase_engine.sv
// Scoreboard bench for harmonic_phase_engine: directed frames with hand-computed LUT addresses.
module tb_harmonic_phase_engine;

    logic        i_Clock = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_Start = 1'b0;
    logic        i_Sync = 1'b0;
    logic [15:0] i_Frequency = 16'd0;
    logic [15:0] i_Freq_Scale = 16'd0;
    logic [6:0]  i_Harmonic_Count = 7'd0;
    logic        i_Ready = 1'b1;
    logic        o_Valid;
    logic [10:0] o_LUT_Addr;
    logic [6:0]  o_Harmonic;
    logic        o_Busy;
    logic        o_Frame_Done;
    logic        o_Freq_Too_High;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [6:0]  harm;
        logic [10:0] addr;
    } exp_t;
    exp_t exp_q[$];

    always #5 i_Clock = ~i_Clock;

    harmonic_phase_engine dut (
        .i_Clock          (i_Clock),
        .i_Reset          (i_Reset),
        .i_Start          (i_Start),
        .i_Sync           (i_Sync),
        .i_Frequency      (i_Frequency),
        .i_Freq_Scale     (i_Freq_Scale),
        .i_Harmonic_Count (i_Harmonic_Count),
        .i_Ready          (i_Ready),
        .o_Valid          (o_Valid),
        .o_LUT_Addr       (o_LUT_Addr),
        .o_Harmonic       (o_Harmonic),
        .o_Busy           (o_Busy),
        .o_Frame_Done     (o_Frame_Done),
        .o_Freq_Too_High  (o_Freq_Too_High)
    );

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int h, input int a);
        exp_t e;
        e.harm = 7'(h);
        e.addr = 11'(a);
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted transfer is popped from the scoreboard and compared
    always @(negedge i_Clock) begin : monitor
        exp_t e;
        if (!i_Reset && o_Valid && i_Ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid_queue_size", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("harmonic_index", o_Harmonic, e.harm);
                check("lut_addr", o_LUT_Addr, e.addr);
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (o_Busy && n < 2000) begin
            @(negedge i_Clock);
            n++;
        end
        if (o_Busy) check({name, "_idle_timeout"}, o_Busy, 0);
    endtask

    task automatic start_frame(input int f, input int fs, input int cnt, input logic sync);
        wait_idle("start");
        @(posedge i_Clock);
        #1;
        i_Frequency      = 16'(f);
        i_Freq_Scale     = 16'(fs);
        i_Harmonic_Count = 7'(cnt);
        i_Sync           = sync;
        i_Start          = 1'b1;
        @(posedge i_Clock);
        #1;
        i_Start = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic too_high);
        int n = 0;
        while (!o_Frame_Done && n < 3000) begin
            @(negedge i_Clock);
            n++;
        end
        check({name, "_done"}, o_Frame_Done, 1);
        check({name, "_too_high"}, o_Freq_Too_High, too_high);
        check({name, "_drained"}, exp_q.size(), 0);
        @(negedge i_Clock);
        check({name, "_done_one_cycle"}, o_Frame_Done, 0);
    endtask

    task automatic watch_clear(input string name, input bit pulse_start);
        int busy_cnt = 0;
        int valid_cnt = 0;
        int done_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge i_Clock);
            busy_cnt  += int'(o_Busy);
            valid_cnt += int'(o_Valid);
            done_cnt  += int'(o_Frame_Done);
            i_Frequency = 16'd1000;
            i_Harmonic_Count = 7'd1;
            i_Start = pulse_start && (i == 10);
        end
        i_Start = 1'b0;
        check({name, "_busy_cycles_63_to_65"}, int'(busy_cnt >= 63 && busy_cnt <= 65), 1);
        check({name, "_idle_after_clear"}, o_Busy, 0);
        check({name, "_no_valid"}, valid_cnt, 0);
        check({name, "_no_done"}, done_cnt, 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int lat;
        int per;
        int bad;
        int n;

        repeat (3) @(posedge i_Clock);
        @(negedge i_Clock);
        check("reset_valid", o_Valid, 0);
        check("reset_busy", o_Busy, 0);
        check("reset_done", o_Frame_Done, 0);
        check("reset_too_high", o_Freq_Too_High, 0);
        check("reset_lut", o_LUT_Addr, 0);
        @(posedge i_Clock);
        #1;
        i_Reset = 1'b0;
        watch_clear("clear", 1'b1);

        // Two frames from cleared phases, with latency and per-harmonic period
        push_exp(0, 31); push_exp(1, 62); push_exp(2, 93);
        start_frame(1000, 0, 3, 1'b0);
        lat = 1;
        while (!o_Valid && lat < 12) begin
            @(negedge i_Clock);
            if (!o_Valid) lat++;
        end
        check("first_valid_latency", lat, 3);
        per = 0;
        do begin
            @(negedge i_Clock);
            per++;
        end while (!o_Valid && per < 12);
        check("harmonic_period", per, 4);
        wait_done("frameA", 1'b0);

        push_exp(0, 62); push_exp(1, 125); push_exp(2, 187);
        start_frame(1000, 0, 3, 1'b0);
        wait_done("frameB", 1'b0);

        // Alternating scale offset: 1000, 1990, 3000, 3980
        push_exp(0, 31); push_exp(1, 62); push_exp(2, 93); push_exp(3, 124);
        start_frame(1000, 10, 4, 1'b1);
        wait_done("frameC", 1'b0);

        // Third harmonic would be 24000 > limit
        push_exp(0, 250); push_exp(1, 500);
        start_frame(8000, 0, 8, 1'b1);
        wait_done("frameD", 1'b1);
        wait_idle("frameD");
        check("too_high_holds_in_idle", o_Freq_Too_High, 1);

        // Backpressure: phases 8000+1000 and 16000+2000
        i_Ready = 1'b0;
        push_exp(0, 281); push_exp(1, 562);
        start_frame(1000, 0, 2, 1'b0);
        @(negedge i_Clock);
        check("too_high_cleared_by_start", o_Freq_Too_High, 0);
        n = 0;
        while (!o_Valid && n < 20) begin
            @(negedge i_Clock);
            n++;
        end
        check("bp_valid_seen", o_Valid, 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_Clock);
            if (!o_Valid || o_LUT_Addr != 11'd281 || o_Harmonic != 7'd0) bad++;
        end
        check("bp_hold_stable", bad, 0);
        @(posedge i_Clock);
        #1;
        i_Ready = 1'b1;
        wait_done("frameE", 1'b0);

        push_exp(0, 31);
        start_frame(1000, 0, 1, 1'b1);
        wait_done("sync", 1'b0);

        // Wrap: 20000, 40000, 60000, 80000 mod 65536 = 14464
        push_exp(0, 625);
        start_frame(20000, 0, 1, 1'b1);
        wait_done("wrap1", 1'b0);
        push_exp(0, 1250);
        start_frame(20000, 0, 1, 1'b0);
        wait_done("wrap2", 1'b0);
        push_exp(0, 1875);
        start_frame(20000, 0, 1, 1'b0);
        wait_done("wrap3", 1'b0);
        push_exp(0, 452);
        start_frame(20000, 0, 1, 1'b0);
        wait_done("wrap4", 1'b0);

        start_frame(20001, 0, 1, 1'b1);
        wait_done("over_limit", 1'b1);

        push_exp(0, 31);
        start_frame(1000, 0, 0, 1'b1);
        wait_done("count_zero", 1'b0);

        for (int k = 0; k < 64; k++) push_exp(k, (100 * (k + 1)) >> 5);
        start_frame(100, 0, 100, 1'b1);
        wait_done("count_clamp", 1'b0);

        // Reset while presenting
        i_Ready = 1'b0;
        start_frame(1000, 0, 2, 1'b0);
        n = 0;
        while (!o_Valid && n < 20) begin
            @(negedge i_Clock);
            n++;
        end
        check("pre_reset_valid", o_Valid, 1);
        @(posedge i_Clock);
        #1;
        i_Reset = 1'b1;
        @(posedge i_Clock);
        @(negedge i_Clock);
        check("midframe_reset_valid", o_Valid, 0);
        exp_q.delete();
        @(posedge i_Clock);
        #1;
        i_Reset = 1'b0;
        i_Ready = 1'b1;
        watch_clear("reclear", 1'b0);
        push_exp(0, 31);
        start_frame(1000, 0, 1, 1'b0);
        wait_done("after_reset", 1'b0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
